// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch controller.
// Buffer depth follows FETCH_CTRL_PREFETCH_EN: two entries when defined, one otherwise.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    CAPTURE
  } state_t;

`ifdef FETCH_CTRL_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam int CNT_W = $clog2(DEPTH + 1);
  // Wide enough for MEM_LAT up to 15.
  localparam int LAT_W = 4;

endpackage

// File: rtl/fetch_buf.sv
// DEPTH-entry FIFO of {pc, instr}; push/pop in one cycle both apply, flush empties it.
// Head is presented combinationally from entry 0 and reads as zero when empty.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_instr,
  input  logic              pop,
  input  logic              flush,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_instr,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [ADDR_W-1:0] pc_d    [DEPTH];
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [DATA_W-1:0] instr_d [DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d, base;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    base    = cnt_q;
    cnt_d   = cnt_q;
    // Pop shifts entries toward the head so the write slot is simply the post-pop count.
    if (pop && (cnt_q != '0)) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        pc_d[i]    = pc_q[i+1];
        instr_d[i] = instr_q[i+1];
      end
      base = cnt_q - CNT_W'(1);
    end
    cnt_d = base;
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (base == CNT_W'(i)) begin
          pc_d[i]    = push_pc;
          instr_d[i] = push_instr;
        end
      end
      cnt_d = base + CNT_W'(1);
    end
    if (flush) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      pc_q    <= '{default: '0};
      instr_q <= '{default: '0};
    end else begin
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign count      = cnt_q;
  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CNT_W'(DEPTH));
  assign head_pc    = empty ? '0 : pc_q[0];
  assign head_instr = empty ? '0 : instr_q[0];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch FSM: one read per MEM_LAT+2 cycles into a small buffer drained by valid/ready.
// Consumer stall stops new requests once buffer+in-flight reaches depth (FETCH_CTRL_PREFETCH_EN sets depth 2).
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MEM_LAT  = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] from_mem,
  output logic [DATA_W-1:0] to_mem,
  output logic              mem_clock,
  output logic              mem_write,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              push, pop, flush, can_req;
  logic [CNT_W-1:0]  buf_count, occ;
  logic              buf_empty, buf_full;

  assign pop = instr_valid & instr_ready;
  // Only evaluated in IDLE/CAPTURE, where nothing is in flight; count this cycle's pop as already gone.
  assign occ     = buf_count - CNT_W'(pop);
  assign can_req = !halt && (occ < CNT_W'(DEPTH));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    lat_d   = lat_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect) begin
      flush   = 1'b1;
      pc_d    = redirect_pc;
      state_d = halt ? IDLE : REQ;
    end else begin
      unique case (state_q)
        IDLE:    if (can_req) state_d = REQ;
        REQ: begin
          state_d = WAIT;
          lat_d   = LAT_W'(MEM_LAT - 1);
        end
        WAIT: begin
          if (lat_q == '0) begin
            push    = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = CAPTURE;
          end else begin
            lat_d = lat_q - LAT_W'(1);
          end
        end
        CAPTURE: state_d = can_req ? REQ : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lat_q   <= lat_d;
      assert (!(push && buf_full && !pop));
    end
  end

  fetch_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_buf (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_pc    (pc_q),
    .push_instr (from_mem),
    .pop        (pop),
    .flush      (flush),
    .head_pc    (instr_pc),
    .head_instr (instr),
    .count      (buf_count),
    .empty      (buf_empty),
    .full       (buf_full)
  );

  assign address     = pc_q;
  assign pc          = pc_q;
  assign mem_clock   = (state_q == REQ);
  assign mem_write   = 1'b0;
  assign to_mem      = '0;
  assign instr_valid = !buf_empty;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 8, meaning program-counter and memory address width.
REQ-002 The block SHALL take parameter DATA_W, default 8, meaning instruction word width.
REQ-003 The block SHALL take parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-004 The block SHALL take parameter MEM_LAT, default 1, range 1..15, meaning cycles from request to read data valid.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset; clock and reset_n are the only clock and reset ports.
REQ-006 clock  in  1  rising-edge clock for all state.
REQ-007 reset_n  in  1  synchronous active-low reset.
REQ-008 address  out  ADDR_W  memory read address.
REQ-009 from_mem  in  DATA_W  memory read data.
REQ-010 to_mem  out  DATA_W  memory write data, held 0.
REQ-011 mem_clock  out  1  one-cycle memory read strobe.
REQ-012 mem_write  out  1  memory write enable, held 0.
REQ-013 instr  out  DATA_W  head instruction word.
REQ-014 instr_pc  out  ADDR_W  address of instr.
REQ-015 instr_valid  out  1  instr/instr_pc valid.
REQ-016 instr_ready  in  1  consumer accepts head when valid & ready.
REQ-017 redirect  in  1  one-cycle jump request.
REQ-018 redirect_pc  in  ADDR_W  jump target.
REQ-019 halt  in  1  suppress new requests.
REQ-020 pc  out  ADDR_W  next fetch address.

Function
REQ-021 The FSM SHALL have states IDLE, REQ, WAIT and CAPTURE; IDLE->REQ when halt=0 and (buffered + in-flight) < DEPTH; REQ->WAIT; WAIT holds MEM_LAT-1 cycles, then ->CAPTURE; CAPTURE->REQ if the IDLE->REQ condition still holds, else ->IDLE.
REQ-022 In REQ, mem_clock SHALL be 1 for exactly one cycle with address=pc; mem_clock SHALL be 0 in all other states.
REQ-023 from_mem SHALL be sampled at the end of cycle t+MEM_LAT, where t is the REQ cycle, and pushed into the buffer with its fetch address; pc SHALL then increment by 1.
REQ-024 pc SHALL wrap modulo 2^ADDR_W, so all-ones increments to 0.
REQ-025 Peak throughput SHALL be one instruction per MEM_LAT+2 cycles.
REQ-026 instr_valid SHALL be 1 whenever the buffer is non-empty; a transfer occurs on a cycle with instr_valid & instr_ready; push and pop in the same cycle SHALL both take effect.
REQ-027 redirect SHALL take priority over every other event: pc<=redirect_pc, the in-flight fetch is discarded, the buffer is flushed, and the FSM goes to REQ (or to IDLE if halt=1) next cycle.
REQ-028 A transfer coincident with redirect SHALL count as accepted; instr_valid SHALL be 0 in the cycle after redirect.
REQ-029 halt SHALL block only new REQ entry; an in-flight fetch completes and the buffer continues to drain.
REQ-030 mem_write and to_mem SHALL be 0 at all times.

Reset
REQ-031 On a clock edge with reset_n=0, the block SHALL set state=IDLE, pc=RESET_PC, buffer empty, instr=0, instr_pc=0, instr_valid=0, mem_clock=0 and address=RESET_PC; any in-flight fetch is dropped, including on reset mid-WAIT.
REQ-032 The first REQ SHALL occur in the cycle after the first edge with reset_n=1 (halt=0).

Configuration
REQ-033 Macro FETCH_CTRL_PREFETCH_EN: if defined, DEPTH=2 (two-entry prefetch buffer; fetch continues while the consumer stalls); if undefined, DEPTH=1 (at most one buffered or in-flight instruction).

Structure
REQ-034 Package fetch_pkg SHALL hold the FSM state enum typedef, MEM_LAT counter width and the DEPTH constant derived from the macro.
REQ-035 Sub-module fetch_buf SHALL be the DEPTH-entry FIFO of {pc, instr} with push, pop, flush, count, empty and full.

Verification (ADDR_W=8, DATA_W=8, MEM_LAT=1, RESET_PC=0, mem[i]=i+0x10)
REQ-036 Reset release with instr_ready=1 -> instr stream 0x10,0x11,0x12 with instr_pc 0,1,2; first instr_valid after the 3rd edge with reset_n=1; one mem_clock pulse every 3 cycles.
REQ-037 instr_ready=0 from reset -> exactly 1 mem_clock pulse (2 with FETCH_CTRL_PREFETCH_EN), instr held at 0x10; on raising instr_ready -> 0x10,0x11 are delivered in order.
REQ-038 redirect to 0x80 during WAIT -> data 0x10 is never delivered; the next pulse has address=0x80, and the next instr=0x90 with instr_pc=0x80.
REQ-039 redirect to 0xFE -> instr_pc sequence 0xFE,0xFF,0x00 with instr 0x0E,0x0F,0x10.
REQ-040 halt=1 during WAIT -> that fetch is delivered and no further mem_clock pulses occur; halt=0 -> the next pulse has address = previous address + 1.
REQ-041 reset_n=0 for one cycle during WAIT -> all outputs take reset values next cycle; after release the fetch restarts at 0x00.
